// File: rtl/cmos_frame_capture.sv
// cmos_frame_capture: registers the camera bus, waits for an armed start-of-frame,
// forwards exactly one whole frame as a valid/ready stream and reports statistics.
module cmos_frame_capture #(
    parameter int DW               = 16,
    parameter int CW               = 20,
    parameter int LW               = 10,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] cmos_data_i,
    input  logic          cmos_vsync_i,
    input  logic          cmos_hsync_i,
    input  logic          cmos_valid_i,
    input  logic          arm_i,
    input  logic          abort_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          overflow_o,
    output logic [CW-1:0] frame_pixels_o,
    output logic [LW-1:0] frame_lines_o,
    output logic [15:0]   drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          vs_act_pin;
    logic [DW-1:0] s1_data;
    logic          s1_vs_act;
    logic          s1_hs;
    logic          s1_valid;
    logic          s2_vs_act;
    logic          s2_hs;

    logic          sof;
    logic          hedge;
    logic          accept;
    logic          start;
    logic          finish;
    logic          load;
    logic          drop;

    logic [DW-1:0] m_data_q;
    logic          m_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          overflow_q;
    logic [CW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [15:0]   drop_cnt;
    logic [CW-1:0] frame_pixels_q;
    logic [LW-1:0] frame_lines_q;

    assign vs_act_pin = VSYNC_ACTIVE_LOW ? ~cmos_vsync_i : cmos_vsync_i;
    assign sof        = s1_vs_act & ~s2_vs_act;
    assign hedge      = s1_hs & ~s2_hs;
    assign accept     = s1_valid & ~sof;

    // Two-stage input registers; vsync stages reset to active so a vsync already
    // asserted at reset is never mistaken for a start-of-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data   <= '0;
            s1_vs_act <= 1'b1;
            s1_hs     <= 1'b0;
            s1_valid  <= 1'b0;
            s2_vs_act <= 1'b1;
            s2_hs     <= 1'b0;
        end else begin
            s1_data   <= cmos_data_i;
            s1_vs_act <= vs_act_pin;
            s1_hs     <= cmos_hsync_i;
            s1_valid  <= cmos_valid_i;
            s2_vs_act <= s1_vs_act;
            s2_hs     <= s1_hs;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle capture decisions; abort overrides everything.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_i) begin
                    state_d = WAIT_SOF;
                    start   = 1'b1;
                end
            end
            WAIT_SOF: begin
                if (sof) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    if (!m_valid_q || m_ready_i) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (sof) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!m_valid_q) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            start   = 1'b0;
            finish  = 1'b0;
            load    = 1'b0;
            drop    = 1'b0;
        end
    end

    // Single-entry output register with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (abort_i) begin
            m_valid_q <= 1'b0;
        end else if (load) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s1_data;
        end else if (m_ready_i) begin
            m_valid_q <= 1'b0;
        end
    end

    // Per-capture counters, cleared when a capture is armed, all saturating.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            drop_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (state_q == CAPTURE && !abort_i) begin
            if (load && pix_cnt != {CW{1'b1}}) begin
                pix_cnt <= pix_cnt + CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            if (hedge && line_cnt != {LW{1'b1}}) begin
                line_cnt <= line_cnt + LW'(1);
            end
        end
    end

    // Completion pulse, busy flag and frame statistics latched on a clean finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            frame_pixels_q <= '0;
            frame_lines_q  <= '0;
        end else begin
            done_q <= finish;
            busy_q <= (state_d != IDLE);
            if (finish) begin
                frame_pixels_q <= pix_cnt;
                frame_lines_q  <= line_cnt;
            end
        end
    end

    assign m_data_o       = m_data_q;
    assign m_valid_o      = m_valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign overflow_o     = overflow_q;
    assign frame_pixels_o = frame_pixels_q;
    assign frame_lines_o  = frame_lines_q;
    assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Testbench for cmos_frame_capture: a cycle-exact vector table for one small frame,
// then hand-written sequences for mid-frame arm, backpressure, drain, abort and reset.
module tb_cmos_frame_capture;

    localparam int DW = 16;
    localparam int CW = 20;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cmos_data = '0;
    logic          cmos_vsync = 1'b1;
    logic          cmos_hsync = 1'b0;
    logic          cmos_valid = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] frame_pixels;
    logic [LW-1:0] frame_lines;
    logic [15:0]   drop_cnt;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [DW-1:0] beats[$];

    logic          prev_stall = 1'b0;
    logic          prev_hold = 1'b1;
    logic [DW-1:0] prev_data = '0;

    typedef struct {
        logic          vs;
        logic          hs;
        logic          valid;
        logic [DW-1:0] data;
        logic          arm;
        logic          ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
        logic          exp_done;
        logic [CW-1:0] exp_pix;
    } vec_t;

    vec_t vec[12];

    cmos_frame_capture dut (
        .clk            (clk),
        .rst            (rst),
        .cmos_data_i    (cmos_data),
        .cmos_vsync_i   (cmos_vsync),
        .cmos_hsync_i   (cmos_hsync),
        .cmos_valid_i   (cmos_valid),
        .arm_i          (arm),
        .abort_i        (abort),
        .m_data_o       (m_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .busy_o         (busy),
        .done_o         (done),
        .overflow_o     (overflow),
        .frame_pixels_o (frame_pixels),
        .frame_lines_o  (frame_lines),
        .drop_cnt_o     (drop_cnt)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Stream monitor on the falling edge: records handshakes, counts done pulses,
    // and checks the output register holds while stalled.
    always @(negedge clk) begin
        if (prev_stall && !prev_hold) begin
            checkOutput("stall_valid", 32'(m_valid), 32'd1);
            checkOutput("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready) beats.push_back(m_data);
        if (done) done_cnt <= done_cnt + 1;
        prev_stall <= m_valid && !m_ready;
        prev_hold  <= abort || rst;
        prev_data  <= m_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vs, input logic hs, input logic valid, input logic [DW-1:0] data,
                                 input logic a, input logic ab, input logic rdy);
        cmos_vsync = vs;
        cmos_hsync = hs;
        cmos_valid = valid;
        cmos_data  = data;
        arm        = a;
        abort      = ab;
        m_ready    = rdy;
        tick();
    endtask

    function automatic vec_t mkVec(input logic vs, input logic hs, input logic valid, input logic [DW-1:0] data,
                                   input logic a, input logic ev, input logic [DW-1:0] ed,
                                   input logic eb, input logic edn, input logic [CW-1:0] ep);
        vec_t v;
        v.vs = vs; v.hs = hs; v.valid = valid; v.data = data; v.arm = a; v.ready = 1'b1;
        v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb; v.exp_done = edn; v.exp_pix = ep;
        return v;
    endfunction

    // vsync pin is active low: one active cycle then three inactive cycles.
    task automatic vsyncPulse(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, rdy);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic sendLine(input int n, input logic [DW-1:0] base, input int arm_at);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, base + DW'(i), (i == arm_at), 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic armCapture();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic waitDone(input int prev, input string name);
        int n = 0;
        while (done_cnt == prev && n < 60) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) tick();
        checkOutput(name, 32'(done_cnt - prev), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(m_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_data"}, 32'(m_data), 32'd0);
        checkOutput({tag, "_pixels"}, 32'(frame_pixels), 32'd0);
        checkOutput({tag, "_lines"}, 32'(frame_lines), 32'd0);
        checkOutput({tag, "_drops"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp3[7];
        int prev_done;

        // Cycle-exact table: arm, SOF, three pixels on one line, ending SOF, done.
        vec[0]  = mkVec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 20'd0);
        vec[1]  = mkVec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 20'd0);
        vec[2]  = mkVec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 20'd0);
        vec[3]  = mkVec(1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 20'd0);
        vec[4]  = mkVec(1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 20'd0);
        vec[5]  = mkVec(1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 20'd0);
        vec[6]  = mkVec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 20'd0);
        vec[7]  = mkVec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 20'd0);
        vec[8]  = mkVec(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 20'd0);
        vec[9]  = mkVec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 20'd0);
        vec[10] = mkVec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 20'd3);
        vec[11] = mkVec(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 20'd3);

        // Reset with vsync inactive.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkResetOutputs("reset0");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vec[i].vs, vec[i].hs, vec[i].valid, vec[i].data, vec[i].arm, 1'b0, vec[i].ready);
            checkOutput($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vec[i].exp_valid));
            if (vec[i].exp_valid) checkOutput($sformatf("vec%0d_data", i), 32'(m_data), 32'(vec[i].exp_data));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vec[i].exp_busy));
            checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'(vec[i].exp_done));
            checkOutput($sformatf("vec%0d_pixels", i), 32'(frame_pixels), 32'(vec[i].exp_pix));
        end
        checkOutput("vec_lines", 32'(frame_lines), 32'd1);

        // Full frame of 4 lines x 8 pixels with ready held high.
        beats.delete();
        prev_done = done_cnt;
        armCapture();
        vsyncPulse(1'b1);
        for (int l = 0; l < 4; l++) sendLine(8, 16'h0100 + DW'(l * 8), -1);
        vsyncPulse(1'b1);
        waitDone(prev_done, "f1_done_once");
        checkOutput("f1_beats", 32'(beats.size()), 32'd32);
        for (int i = 0; i < beats.size() && i < 32; i++)
            checkOutput($sformatf("f1_beat%0d", i), 32'(beats[i]), 32'h0100 + 32'(i));
        checkOutput("f1_pixels", 32'(frame_pixels), 32'd32);
        checkOutput("f1_lines", 32'(frame_lines), 32'd4);
        checkOutput("f1_overflow", 32'(overflow), 32'd0);
        checkOutput("f1_busy", 32'(busy), 32'd0);

        // Arm during line 2 of frame A; only frame B (2 x 8) is forwarded.
        beats.delete();
        prev_done = done_cnt;
        vsyncPulse(1'b1);
        sendLine(8, 16'hA000, -1);
        sendLine(8, 16'hA008, 3);
        sendLine(8, 16'hA010, -1);
        sendLine(8, 16'hA018, -1);
        vsyncPulse(1'b1);
        sendLine(8, 16'hB000, -1);
        sendLine(8, 16'hB008, -1);
        vsyncPulse(1'b1);
        waitDone(prev_done, "f2_done_once");
        checkOutput("f2_beats", 32'(beats.size()), 32'd16);
        if (beats.size() == 16) begin
            checkOutput("f2_first", 32'(beats[0]), 32'hB000);
            checkOutput("f2_last", 32'(beats[15]), 32'hB00F);
        end
        checkOutput("f2_pixels", 32'(frame_pixels), 32'd16);
        checkOutput("f2_lines", 32'(frame_lines), 32'd2);

        // Backpressure: ready low for 3 cycles inside a burst of 10 pixels.
        exp3 = '{16'hC000, 16'hC001, 16'hC002, 16'hC006, 16'hC007, 16'hC008, 16'hC009};
        beats.delete();
        prev_done = done_cnt;
        armCapture();
        vsyncPulse(1'b1);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'hC000 + DW'(i), 1'b0, 1'b0, !(i >= 4 && i <= 6));
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        vsyncPulse(1'b1);
        waitDone(prev_done, "bp_done_once");
        checkOutput("bp_beats", 32'(beats.size()), 32'd7);
        for (int i = 0; i < beats.size() && i < 7; i++)
            checkOutput($sformatf("bp_beat%0d", i), 32'(beats[i]), 32'(exp3[i]));
        checkOutput("bp_drops", 32'(drop_cnt), 32'd3);
        checkOutput("bp_overflow", 32'(overflow), 32'd1);
        checkOutput("bp_pixels", 32'(frame_pixels), 32'd7);

        // Drain: one pixel stuck in the output register across the ending SOF.
        beats.delete();
        prev_done = done_cnt;
        armCapture();
        vsyncPulse(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hD001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        vsyncPulse(1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("dr_no_done", 32'(done_cnt - prev_done), 32'd0);
        checkOutput("dr_held_valid", 32'(m_valid), 32'd1);
        checkOutput("dr_held_data", 32'(m_data), 32'hD001);
        checkOutput("dr_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("dr_done_edge0", 32'(done), 32'd0);
        checkOutput("dr_valid_gone", 32'(m_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("dr_done_edge1", 32'(done), 32'd1);
        checkOutput("dr_busy_low", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("dr_done_edge2", 32'(done), 32'd0);
        checkOutput("dr_beats", 32'(beats.size()), 32'd1);
        checkOutput("dr_pixels", 32'(frame_pixels), 32'd1);
        checkOutput("dr_lines", 32'(frame_lines), 32'd1);

        // Abort in CAPTURE after 5 pixels have been delivered.
        beats.delete();
        prev_done = done_cnt;
        armCapture();
        vsyncPulse(1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, 16'hE000 + DW'(i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hE006, 1'b0, 1'b1, 1'b1);
        checkOutput("ab_valid", 32'(m_valid), 32'd0);
        checkOutput("ab_busy", 32'(busy), 32'd0);
        checkOutput("ab_beats", 32'(beats.size()), 32'd5);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        vsyncPulse(1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("ab_no_done", 32'(done_cnt - prev_done), 32'd0);
        checkOutput("ab_pixels_kept", 32'(frame_pixels), 32'd1);
        checkOutput("ab_idle", 32'(busy), 32'd0);

        // Reset with vsync already active; capture only after a fresh assertion.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkResetOutputs("reset1");
        rst = 1'b0;
        beats.delete();
        prev_done = done_cnt;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 16'h5000 + DW'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 16'h5100 + DW'(i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("rv_no_beats", 32'(beats.size()), 32'd0);
        checkOutput("rv_busy", 32'(busy), 32'd1);
        vsyncPulse(1'b1);
        sendLine(4, 16'hF000, -1);
        vsyncPulse(1'b1);
        waitDone(prev_done, "rv_done_once");
        checkOutput("rv_beats", 32'(beats.size()), 32'd4);
        if (beats.size() > 0) checkOutput("rv_first", 32'(beats[0]), 32'hF000);
        checkOutput("rv_pixels", 32'(frame_pixels), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmos_frame_capture.md
# cmos_frame_capture

Frame-synchronous capture gate between the camera pad buffers and `stream_upsizer`, running entirely in the camera pixel clock domain. It registers the 16-bit camera bus, waits for an armed start-of-frame, and forwards exactly one whole frame of valid pixels as a valid/ready stream. While forwarding, it counts pixels, lines and dropped pixels, and reports completion once the last pixel has left its output register. It replaces the level-style enable mask on the upsizer input. A partial frame therefore never enters the FIFO.

## Interface
Parameters:
- `DW`, 16, pixel data width
- `CW`, 20, pixel counter width (640×512 fits)
- `LW`, 10, line counter width
- `VSYNC_ACTIVE_LOW`, 1, 1 = vsync asserted when the pin is low

Ports:
- `clk` in 1: camera pixel clock; all logic is on the rising edge
- `rst` in 1: reset, synchronous and active-high
- `cmos_data_i` in DW: pixel data
- `cmos_vsync_i` in 1: frame sync; polarity set by `VSYNC_ACTIVE_LOW`
- `cmos_hsync_i` in 1: line sync, active-high
- `cmos_valid_i` in 1: pixel qualifier
- `arm_i` in 1: one-cycle request to capture the next frame; already synchronised to `clk`
- `abort_i` in 1: return to IDLE immediately; no `done_o`
- `m_data_o` out DW: stream data to the upsizer
- `m_valid_o` out 1: stream valid
- `m_ready_i` in 1: stream ready
- `busy_o` out 1: high in WAIT_SOF, CAPTURE and DRAIN
- `done_o` out 1: one-cycle pulse when a frame is complete and drained
- `overflow_o` out 1: sticky, at least one pixel dropped this capture
- `frame_pixels_o` out CW: pixels forwarded in the last completed frame
- `frame_lines_o` out LW: hsync rising edges counted in the last completed frame
- `drop_cnt_o` out 16: pixels dropped this capture, saturating

## Operation
Input stage and events:
- All `cmos_*` inputs are registered once (stage S1). A second register holds `vs_act` and `hs`, giving S2.
- `vs_act` is vsync normalised to active-high.
- `sof` = `vs_act`(S1) & !`vs_act`(S2).
- `hedge` = `hs`(S1) & !`hs`(S2).
- The S2 `vs_act` register resets to 1, so a vsync already active at reset is not an SOF.

State machine (`rst` → IDLE):
- IDLE: `arm_i` → WAIT_SOF. On the transition, clear the pixel counter, line counter, `drop_cnt_o` and `overflow_o`.
- WAIT_SOF: `sof` → CAPTURE. `arm_i` is ignored.
- CAPTURE, per cycle:
  - accept condition: `valid`(S1) & !`sof`
  - accepted pixel with the output register empty or being drained this cycle (`m_ready_i`): load the register, pixel counter +1 (saturating at 2^CW-1)
  - accepted pixel otherwise: drop it, `drop_cnt_o` +1 (saturating at 0xFFFF), `overflow_o` ← 1
  - `hedge` increments the line counter (saturating)
  - `sof` ends the frame → DRAIN; the S1 pixel in that cycle is not captured
- DRAIN: when `m_valid_o` = 0 → IDLE. On that edge, pulse `done_o` and latch `frame_pixels_o` and `frame_lines_o`.
- `abort_i` in any state → IDLE next edge:
  - output register cleared (`m_valid_o` ← 0)
  - no `done_o`; latched frame outputs unchanged
  - `abort_i` wins over a simultaneous `arm_i` or `sof`
- `arm_i` and `sof` in the same cycle while in IDLE: go to WAIT_SOF only; that SOF is missed.

Output register:
- Standard valid/ready. Data is held stable while `m_valid_o` & !`m_ready_i`.
- Holds one entry; there is no skid buffer.

## Timing
- Reset values:
  - `m_valid_o`, `busy_o`, `done_o`, `overflow_o`: 0
  - `m_data_o`, `frame_pixels_o`, `frame_lines_o`, `drop_cnt_o`: 0
  - state: IDLE
- Pixel latency: a pin value sampled at edge E0 appears on `m_valid_o`/`m_data_o` after edge E1, i.e. two edges, assuming `m_ready_i` = 1.
- SOF: vsync assertion sampled at E0 changes state at E1.
- Throughput: one pixel per clock with `m_ready_i` held high.
- `busy_o` is registered and follows the state. It goes high the edge after `arm_i` and low on the same edge `done_o` pulses.
- `done_o` is high for exactly one cycle. It comes no earlier than the edge after the last pixel handshake.

## Test plan
- Arm; frame of 4 lines × 8 pixels; vsync pulse; `m_ready_i`=1.
  - 32 beats, data in order.
  - `frame_pixels_o`=32, `frame_lines_o`=4, `done_o` one cycle, `overflow_o`=0.
- Arm mid-frame: arm during line 2 of frame A, then full frame B of 16 pixels.
  - No frame A pixels forwarded.
  - `frame_pixels_o`=16.
- Backpressure: `m_ready_i` low for 3 cycles during a continuous valid burst of 10.
  - `drop_cnt_o`=3, `overflow_o`=1.
  - 7 beats delivered with data stable while stalled.
- Drain: hold `m_ready_i`=0 across the ending SOF with one pixel in the register.
  - `done_o` stays low.
  - `done_o` pulses the edge after `m_ready_i` rises.
- Abort in CAPTURE after 5 pixels.
  - `m_valid_o`=0 and `busy_o`=0 next edge.
  - No `done_o`; `frame_pixels_o` keeps its previous value.
- Reset with `cmos_vsync_i` already active; release; arm.
  - No capture until the next inactive→active vsync transition.
  - All outputs 0 during reset.
